riscv_mem_harness: RTL and testbench

//  Synthesizable self-check harness for the RISC-V CPU top. It preloads up to N_PRE words through the

---
 rtl/riscv_harness_pkg.sv | 27 ++
 rtl/riscv_mem_harness_if.sv | 24 ++
 rtl/riscv_harness_table.sv | 63 ++++++
 rtl/riscv_mem_harness.sv | 199 +++++++++++++++++++
 tb/tb_riscv_mem_harness.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_harness_pkg.sv
`default_nettype none
// ============================================================================
// Package  : riscv_harness_pkg
// Purpose  : Shared types and constants for the RISC-V memory self-check
//            harness: FSM state encoding, failure codes, index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_MONITOR = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_ADDR    = 2'd1;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd2;

  // Index width for a table of the given depth; never narrower than one bit
  function automatic int idx_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_mem_harness_if.sv
`default_nettype none
// ============================================================================
// Interface : riscv_mem_harness_if
// Purpose   : Simple data-memory write bus (enable, address, data).
//             master drives the bus, slave observes it. Used both for the
//             CPU write port the harness watches and for the external
//             memory port the harness preloads through.
// Signals   : MemWrite  - write enable
//             DataAdr   - write address (AW bits)
//             WriteData - write data (DW bits)
// Revision  : 1.0 - initial release
// ============================================================================
interface riscv_mem_harness_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          MemWrite;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;

  modport master (output MemWrite, DataAdr, WriteData);
  modport slave  (input  MemWrite, DataAdr, WriteData);
endinterface
`default_nettype wire

// File: rtl/riscv_harness_table.sv
`default_nettype none
// ============================================================================
// Module   : riscv_harness_table
// Purpose  : Register file holding the preload bank and the check bank,
//            each DEPTH entries of (address, data). Contents are not reset.
// Ports    : clk                 - clock
//            we/sel/widx         - write strobe, bank (0 pre, 1 chk), index
//            waddr/wdata         - entry written
//            pre_idx -> pre_*    - read port into preload bank
//            chk_idx -> chk_*    - read port into check bank
//            probe_addr -> in_chk- per-entry check-bank address compare
// Revision : 1.0 - initial release
// ============================================================================
module riscv_harness_table #(
  parameter int DEPTH = 4,
  parameter int IW    = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic             sel,
  input  wire logic [IW-1:0]    widx,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [DW-1:0]    wdata,
  input  wire logic [IW-1:0]    pre_idx,
  output logic      [AW-1:0]    pre_addr,
  output logic      [DW-1:0]    pre_data,
  input  wire logic [IW-1:0]    chk_idx,
  output logic      [AW-1:0]    chk_addr,
  output logic      [DW-1:0]    chk_data,
  input  wire logic [AW-1:0]    probe_addr,
  output logic      [DEPTH-1:0] in_chk
);

  logic [AW-1:0] r_pre_addr [DEPTH];
  logic [DW-1:0] r_pre_data [DEPTH];
  logic [AW-1:0] r_chk_addr [DEPTH];
  logic [DW-1:0] r_chk_data [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      if (!sel) begin
        r_pre_addr[widx] <= waddr;
        r_pre_data[widx] <= wdata;
      end else begin
        r_chk_addr[widx] <= waddr;
        r_chk_data[widx] <= wdata;
      end
    end
  end

  assign pre_addr = r_pre_addr[pre_idx];
  assign pre_data = r_pre_data[pre_idx];
  assign chk_addr = r_chk_addr[chk_idx];
  assign chk_data = r_chk_data[chk_idx];

  for (genvar k = 0; k < DEPTH; k++) begin : g_probe
    assign in_chk[k] = (r_chk_addr[k] == probe_addr);
  end

endmodule
`default_nettype wire

// File: rtl/riscv_mem_harness.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_harness
// Purpose  : Self-check harness for the RISC-V CPU top. Preloads memory via
//            the external port with the CPU held in reset, releases the CPU,
//            then watches its data writes for an ordered list of expected
//            (address, data) pairs and reports pass / fail / timeout.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            cfg_*               - table programming (IDLE/DONE only)
//            n_pre, n_chk        - active entry counts, latched on start
//            ign_base, ign_mask  - ignore window for CPU writes
//            start               - begin a run (IDLE/DONE only)
//            cpu_bus (slave)     - CPU data-memory write bus
//            ext_bus (master)    - external memory preload bus
//            cpu_reset, busy, done, pass, fail_code, fail_addr, match_cnt
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_harness
  import riscv_harness_pkg::*;
#(
  parameter  int AW      = 32,
  parameter  int DW      = 32,
  parameter  int N_PRE   = 4,
  parameter  int N_CHK   = 4,
  parameter  int TIMEOUT = 20000,
  parameter  int STRICT  = 1,
  localparam int DEPTH   = (N_PRE > N_CHK) ? N_PRE : N_CHK,
  localparam int IW      = idx_width(DEPTH),
  localparam int PW      = $clog2(N_PRE + 1),
  localparam int CW      = $clog2(N_CHK + 1)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          cfg_we,
  input  wire logic          cfg_sel,
  input  wire logic [IW-1:0] cfg_idx,
  input  wire logic [AW-1:0] cfg_addr,
  input  wire logic [DW-1:0] cfg_data,
  input  wire logic [PW-1:0] n_pre,
  input  wire logic [CW-1:0] n_chk,
  input  wire logic [AW-1:0] ign_base,
  input  wire logic [AW-1:0] ign_mask,
  input  wire logic          start,
  riscv_mem_harness_if.slave  cpu_bus,
  riscv_mem_harness_if.master ext_bus,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [1:0]         fail_code,
  output logic [AW-1:0]      fail_addr,
  output logic [CW-1:0]      match_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          r_state, w_state_next;
  logic [PW-1:0]   r_n_pre, r_pre_idx, w_n_pre_lim;
  logic [CW-1:0]   r_n_chk, r_match_cnt, w_n_chk_lim;
  logic            r_phase;
  logic [TW-1:0]   r_cyc;
  logic            r_pass;
  logic [1:0]      r_fail_code;
  logic [AW-1:0]   r_fail_addr;

  logic            w_cfg_open, w_start_run, w_hit, w_listed, w_ignored;
  logic            w_dec_pass, w_dec_fail, w_dec_timeout, w_ext_we;
  logic [AW-1:0]   w_pre_addr, w_chk_addr;
  logic [DW-1:0]   w_pre_data, w_chk_data;
  logic [DEPTH-1:0] w_in_chk, w_active;

  assign w_cfg_open  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  // Counts above the table depth would read past the table; clamp them.
  assign w_n_pre_lim = (n_pre > PW'(N_PRE)) ? PW'(N_PRE) : n_pre;
  assign w_n_chk_lim = (n_chk > CW'(N_CHK)) ? CW'(N_CHK) : n_chk;

  riscv_harness_table #(.DEPTH(DEPTH), .IW(IW), .AW(AW), .DW(DW)) u_table (
    .clk        (clk),
    .we         (cfg_we && w_cfg_open),
    .sel        (cfg_sel),
    .widx       (cfg_idx),
    .waddr      (cfg_addr),
    .wdata      (cfg_data),
    .pre_idx    (IW'(r_pre_idx)),
    .pre_addr   (w_pre_addr),
    .pre_data   (w_pre_data),
    .chk_idx    (IW'(r_match_cnt)),
    .chk_addr   (w_chk_addr),
    .chk_data   (w_chk_data),
    .probe_addr (cpu_bus.DataAdr),
    .in_chk     (w_in_chk)
  );

  // Only entries below the latched n_chk count as "listed" addresses
  for (genvar k = 0; k < DEPTH; k++) begin : g_active
    assign w_active[k] = (int'(r_n_chk) > k);
  end

  assign w_listed  = |(w_in_chk & w_active);
  assign w_ignored = ((cpu_bus.DataAdr & ign_mask) == ign_base);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_start_run   = 1'b0;
    w_hit         = 1'b0;
    w_dec_pass    = 1'b0;
    w_dec_fail    = 1'b0;
    w_dec_timeout = 1'b0;
    w_ext_we      = 1'b0;
    cpu_reset     = 1'b1;
    busy          = 1'b0;
    done          = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        done = (r_state == ST_DONE);
        if (start) begin
          w_start_run  = 1'b1;
          w_state_next = (w_n_pre_lim == '0) ? ST_MONITOR : ST_PRELOAD;
        end
      end
      ST_PRELOAD: begin
        busy     = 1'b1;
        w_ext_we = !r_phase;
        if (r_phase && (r_pre_idx == r_n_pre - PW'(1))) w_state_next = ST_MONITOR;
      end
      ST_MONITOR: begin
        busy      = 1'b1;
        cpu_reset = 1'b0;
        w_hit = cpu_bus.MemWrite && (r_match_cnt < r_n_chk) &&
                (cpu_bus.DataAdr == w_chk_addr) && (cpu_bus.WriteData == w_chk_data);
        // Completion beats a stray write, which beats the timeout
        if ((r_match_cnt == r_n_chk) || (w_hit && (r_match_cnt + CW'(1) == r_n_chk)))
          w_dec_pass = 1'b1;
        else if (cpu_bus.MemWrite && !w_hit && !w_listed && !w_ignored && (STRICT != 0))
          w_dec_fail = 1'b1;
        else if (r_cyc == TW'(TIMEOUT - 1))
          w_dec_timeout = 1'b1;
        if (w_dec_pass || w_dec_fail || w_dec_timeout) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_n_pre     <= '0;
      r_n_chk     <= '0;
      r_pre_idx   <= '0;
      r_phase     <= 1'b0;
      r_cyc       <= '0;
      r_match_cnt <= '0;
      r_pass      <= 1'b0;
      r_fail_code <= FAIL_NONE;
      r_fail_addr <= '0;
    end else begin
      if (w_start_run) begin
        r_n_pre     <= w_n_pre_lim;
        r_n_chk     <= w_n_chk_lim;
        r_pre_idx   <= '0;
        r_phase     <= 1'b0;
        r_cyc       <= '0;
        r_match_cnt <= '0;
        r_pass      <= 1'b0;
        r_fail_code <= FAIL_NONE;
        r_fail_addr <= '0;
      end
      if (r_state == ST_PRELOAD) begin
        r_phase <= ~r_phase;
        if (r_phase) r_pre_idx <= r_pre_idx + PW'(1);
      end
      if (r_state == ST_MONITOR) begin
        r_cyc <= r_cyc + TW'(1);
        if (w_hit)         r_match_cnt <= r_match_cnt + CW'(1);
        if (w_dec_pass)    r_pass      <= 1'b1;
        if (w_dec_fail) begin
          r_fail_code <= FAIL_ADDR;
          r_fail_addr <= cpu_bus.DataAdr;
        end
        if (w_dec_timeout) r_fail_code <= FAIL_TIMEOUT;
      end
    end
  end

  assign ext_bus.MemWrite  = w_ext_we;
  assign ext_bus.DataAdr   = w_ext_we ? w_pre_addr : '0;
  assign ext_bus.WriteData = w_ext_we ? w_pre_data : '0;

  assign pass      = r_pass;
  assign fail_code = r_fail_code;
  assign fail_addr = r_fail_addr;
  assign match_cnt = r_match_cnt;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_harness.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_harness
// Purpose  : Self-checking bench for riscv_mem_harness. A behavioural model
//            walks the CPU write sequence against the ordered check list and
//            predicts the decision cycle and final status of each run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_harness;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NP  = 4;
  localparam int NC  = 4;
  localparam int TMO = 64;
  localparam int LIMIT = 2 * NP + TMO + 10;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, cfg_we, cfg_sel, start;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data, ign_base, ign_mask;
  logic [2:0]  n_pre, n_chk;
  logic        cpu_reset, busy, done, pass;
  logic [1:0]  fail_code;
  logic [31:0] fail_addr;
  logic [2:0]  match_cnt;

  riscv_mem_harness_if #(.AW(AW), .DW(DW)) cpu_bus ();
  riscv_mem_harness_if #(.AW(AW), .DW(DW)) ext_bus ();

  riscv_mem_harness #(.AW(AW), .DW(DW), .N_PRE(NP), .N_CHK(NC), .TIMEOUT(TMO), .STRICT(1)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .n_pre(n_pre), .n_chk(n_chk),
    .ign_base(ign_base), .ign_mask(ign_mask), .start(start),
    .cpu_bus(cpu_bus), .ext_bus(ext_bus),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .fail_addr(fail_addr), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] pre_a [NP], pre_d [NP], chk_a [NC], chk_d [NC];
  logic [31:0] ign_b, ign_m;
  wr_t         wq[$];

  int          exp_m, exp_mc;
  logic        exp_pass;
  logic [1:0]  exp_code;
  logic [31:0] exp_faddr;

  // Reference: walk monitor cycles, apply ordered-match / listed / ignore rules
  task automatic model(input int nchk);
    int   mc;
    wr_t  w;
    bit   listed;
    mc = 0; exp_m = -1; exp_pass = 1'b0; exp_code = 2'd0; exp_faddr = 32'd0;
    for (int m = 0; m < TMO && exp_m < 0; m++) begin
      w = '0;
      if (m < wq.size()) w = wq[m];
      if (mc == nchk) begin
        exp_m = m; exp_pass = 1'b1;
      end else if (w.we && w.a == chk_a[mc] && w.d == chk_d[mc]) begin
        mc++;
        if (mc == nchk) begin exp_m = m; exp_pass = 1'b1; end
      end else if (w.we) begin
        listed = 1'b0;
        for (int j = 0; j < nchk; j++) if (chk_a[j] == w.a) listed = 1'b1;
        if (!listed && ((w.a & ign_m) != ign_b)) begin
          exp_m = m; exp_code = 2'd1; exp_faddr = w.a;
        end
      end
      if (exp_m < 0 && m == TMO - 1) begin exp_m = m; exp_code = 2'd2; end
    end
    exp_mc = mc;
  endtask

  task automatic load_tables();
    for (int i = 0; i < NP; i++) begin
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 2'(i); cfg_addr = pre_a[i]; cfg_data = pre_d[i];
      @(negedge clk);
    end
    for (int i = 0; i < NC; i++) begin
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_idx = 2'(i); cfg_addr = chk_a[i]; cfg_data = chk_d[i];
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  // One run: start, check preload pattern, feed CPU writes, check result.
  // abort_t >= 0 asserts reset at that cycle; poke tries start/cfg_we while busy.
  task automatic run(input string tag, input int npre, input int nchk,
                     input int abort_t, input bit poke);
    bit fin;
    int m;
    logic ew;
    logic [31:0] ea, ed;
    model(nchk);
    n_pre = 3'(npre); n_chk = 3'(nchk); ign_base = ign_b; ign_mask = ign_m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fin = 1'b0;
    for (int t = 0; t < LIMIT && !fin; t++) begin
      if (t == abort_t) begin
        reset = 1'b1; cpu_bus.MemWrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({cpu_reset, busy, done, pass, fail_code, fail_addr, match_cnt, ext_bus.MemWrite} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0}) begin
          errors++;
          $display("FAIL %s abort got rst=%b busy=%b done=%b pass=%b code=%0d fa=%h mc=%0d ext=%b want 1,0,0,0,0,0,0,0",
                   tag, cpu_reset, busy, done, pass, fail_code, fail_addr, match_cnt, ext_bus.MemWrite);
        end
        return;
      end
      if (t < 2 * npre) begin
        ew = (t % 2 == 0);
        ea = ew ? pre_a[t/2] : 32'd0;
        ed = ew ? pre_d[t/2] : 32'd0;
        checks++;
        if ({ext_bus.MemWrite, ext_bus.DataAdr, ext_bus.WriteData, cpu_reset, busy} !== {ew, ea, ed, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL %s preload t=%0d got we=%b adr=%h dat=%h rst=%b busy=%b want we=%b adr=%h dat=%h rst=1 busy=1",
                   tag, t, ext_bus.MemWrite, ext_bus.DataAdr, ext_bus.WriteData, cpu_reset, busy, ew, ea, ed);
        end
      end else begin
        m = t - 2 * npre;
        if (m <= exp_m) begin
          checks++;
          if ({cpu_reset, busy, done, ext_bus.MemWrite} !== 4'b0100) begin
            errors++;
            $display("FAIL %s monitor m=%0d got rst=%b busy=%b done=%b ext=%b want 0,1,0,0",
                     tag, m, cpu_reset, busy, done, ext_bus.MemWrite);
          end
          if (m < wq.size()) begin
            cpu_bus.MemWrite = wq[m].we; cpu_bus.DataAdr = wq[m].a; cpu_bus.WriteData = wq[m].d;
          end else begin
            cpu_bus.MemWrite = 1'b0;
          end
        end else begin
          cpu_bus.MemWrite = 1'b0;
          fin = 1'b1;
          checks++;
          if ({done, busy, cpu_reset} !== 3'b101) begin
            errors++;
            $display("FAIL %s done_flags got done=%b busy=%b rst=%b want 1,0,1", tag, done, busy, cpu_reset);
          end
          checks++;
          if ({pass, fail_code, fail_addr, match_cnt} !== {exp_pass, exp_code, exp_faddr, 3'(exp_mc)}) begin
            errors++;
            $display("FAIL %s result got pass=%b code=%0d fa=%h mc=%0d want pass=%b code=%0d fa=%h mc=%0d",
                     tag, pass, fail_code, fail_addr, match_cnt, exp_pass, exp_code, exp_faddr, exp_mc);
          end
        end
      end
      if (poke && t == 1 && !fin) begin
        start = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b1; cfg_idx = 2'd0;
        cfg_addr = $urandom; cfg_data = $urandom;
      end
      if (!fin) begin
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s no_done got done=%b want done within %0d cycles", tag, done, LIMIT);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_reset, busy, done, pass} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got rst=%b busy=%b done=%b pass=%b want 1,0,0,0", cpu_reset, busy, done, pass);
    end
    checks++;
    if ({fail_code, fail_addr, match_cnt} !== 37'd0) begin
      errors++;
      $display("FAIL reset_status got code=%0d fa=%h mc=%0d want 0", fail_code, fail_addr, match_cnt);
    end
    checks++;
    if ({ext_bus.MemWrite, ext_bus.DataAdr, ext_bus.WriteData} !== 65'd0) begin
      errors++;
      $display("FAIL reset_ext got we=%b adr=%h dat=%h want 0", ext_bus.MemWrite, ext_bus.DataAdr, ext_bus.WriteData);
    end
  endtask

  task automatic test_book();
    for (int i = 0; i < NC; i++) begin chk_a[i] = 32'h4000 + 32'(i * 4); chk_d[i] = $urandom; end
    chk_a[0] = 32'd100; chk_d[0] = 32'd25;
    ign_b = 32'd96; ign_m = 32'hFFFF_FFFF;
    load_tables();
    wq.delete();
    wq.push_back('{1'b1, 32'd96, $urandom});
    wq.push_back('{1'b0, 32'd0, 32'd0});
    wq.push_back('{1'b1, 32'd100, 32'd25});
    run("book", 0, 1, -1, 1'b0);
    // status must hold while idling in DONE
    repeat (3) @(negedge clk);
    checks++;
    if ({done, pass, match_cnt} !== {1'b1, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL book_hold got done=%b pass=%b mc=%0d want 1,1,1", done, pass, match_cnt);
    end
    wq.delete();
    wq.push_back('{1'b1, 32'd96, 32'd3});
    wq.push_back('{1'b1, 32'd104, 32'd7});
    run("book_strict", 0, 1, -1, 1'b0);
  endtask

  task automatic test_preload();
    for (int i = 0; i < NP; i++) begin pre_a[i] = $urandom; pre_d[i] = $urandom; end
    load_tables();
    wq.delete();
    run("preload3", 3, 0, -1, 1'b0);
    run("chk0", 0, 0, -1, 1'b0);
  endtask

  task automatic test_sum();
    int s;
    pre_a[0] = 32'h0200_0000; pre_d[0] = 32'd20;
    chk_a[0] = 32'h0200_0004; chk_d[0] = 32'd210;
    chk_a[1] = 32'h0200_0008; chk_d[1] = 32'd1;
    ign_b = 32'd96; ign_m = 32'hFFFF_FFFF;
    load_tables();
    wq.delete(); s = 0;
    for (int i = 1; i <= 20; i++) begin
      s += i;
      if ($urandom_range(0, 1) == 1) wq.push_back('{1'b0, 32'd0, 32'd0});
      wq.push_back('{1'b1, 32'h0200_0004, 32'(s)});
    end
    wq.push_back('{1'b1, 32'h0200_0008, 32'd1});
    run("sum_pass", 1, 2, -1, 1'b0);
    wq.delete(); s = 0;
    wq.push_back('{1'b1, 32'h0200_0008, 32'd1});
    for (int i = 1; i < 20; i++) begin
      s += i;
      wq.push_back('{1'b1, 32'h0200_0004, 32'(s)});
    end
    run("sum_early_flag", 1, 2, -1, 1'b0);
  endtask

  task automatic test_abort();
    for (int i = 0; i < NP; i++) begin pre_a[i] = $urandom; pre_d[i] = $urandom; end
    chk_a[0] = 32'd100; chk_d[0] = 32'd25;
    ign_b = 32'd96; ign_m = 32'hFFFF_FFFF;
    load_tables();
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back('{1'b1, 32'd96, $urandom});
    wq.push_back('{1'b1, 32'd100, 32'd25});
    run("abort_mon", 2, 1, 6, 1'b0);
    run("abort_pre", 2, 1, 0, 1'b0);
    run("restart", 2, 1, -1, 1'b0);
  endtask

  task automatic test_busy_ignored();
    wq.delete();
    wq.push_back('{1'b1, 32'd100, 32'd25});
    run("poke", 2, 1, -1, 1'b1);
    run("poke_after", 2, 1, -1, 1'b0);
  endtask

  task automatic test_random();
    int nchk, npre;
    for (int it = 0; it < 10; it++) begin
      nchk = $urandom_range(1, NC);
      npre = $urandom_range(0, NP);
      ign_b = 32'h8000_0000; ign_m = 32'hF000_0000;
      for (int i = 0; i < NP; i++) begin pre_a[i] = $urandom; pre_d[i] = $urandom; end
      for (int i = 0; i < NC; i++) begin
        chk_a[i] = 32'h1000 + 32'(i * 16) + 32'($urandom_range(0, 3) * 4);
        chk_d[i] = $urandom;
      end
      load_tables();
      wq.delete();
      for (int k = 0; k < nchk; k++) begin
        repeat ($urandom_range(0, 2)) begin
          case ($urandom_range(0, 2))
            0:       wq.push_back('{1'b0, 32'd0, 32'd0});
            1:       wq.push_back('{1'b1, chk_a[$urandom_range(0, nchk - 1)], $urandom});
            default: wq.push_back('{1'b1, 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC), $urandom});
          endcase
        end
        if (!(k == nchk - 1 && $urandom_range(0, 4) == 0))
          wq.push_back('{1'b1, chk_a[k], chk_d[k]});
        if ($urandom_range(0, 9) == 0)
          wq.push_back('{1'b1, 32'h2000 + 32'($urandom_range(0, 255) * 4), $urandom});
      end
      run($sformatf("rand%0d", it), npre, nchk, -1, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_idx = 2'd0; cfg_addr = 32'd0; cfg_data = 32'd0;
    n_pre = 3'd0; n_chk = 3'd0; ign_base = 32'd0; ign_mask = 32'd0; start = 1'b0;
    cpu_bus.MemWrite = 1'b0; cpu_bus.DataAdr = 32'd0; cpu_bus.WriteData = 32'd0;
    for (int i = 0; i < NP; i++) begin pre_a[i] = 32'd0; pre_d[i] = 32'd0; end
    for (int i = 0; i < NC; i++) begin chk_a[i] = 32'd0; chk_d[i] = 32'd0; end
    ign_b = 32'd0; ign_m = 32'd0;
    @(negedge clk);
    test_reset();
    test_book();
    test_preload();
    test_sum();
    test_abort();
    test_busy_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
